// File: rtl/aoi_stimulus_sequencer.sv
// Start/stop controlled 16-code sweep source for the four-input AOI gate.
// Define GRAY_SEQ_EN to emit Gray-coded {a,b,c,d} instead of plain binary.
module aoi_stimulus_sequencer #(
    parameter int DIV        = 4,
    parameter int NUM_PASSES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       step_strobe,
    output logic       busy,
    output logic       done,
    output logic [7:0] pass_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [15:0] LP_DIV_M1 = 16'(DIV - 1);
    localparam logic [7:0]  LP_PASSES = 8'(NUM_PASSES);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_presc;
    logic [15:0] w_presc_nxt;
    logic [3:0]  r_bin;
    logic [3:0]  w_bin_nxt;
    logic [7:0]  r_pass;
    logic [7:0]  w_pass_nxt;
    logic [7:0]  w_pass_inc;
    logic        w_strobe_nxt;
    logic [3:0]  w_code_nxt;
    logic [3:0]  r_code;
    logic        r_strobe;
    logic        r_busy;
    logic        r_done;

    assign w_pass_inc = r_pass + 8'd1;

    always_comb begin
        w_state_nxt  = r_state;
        w_presc_nxt  = r_presc;
        w_bin_nxt    = r_bin;
        w_pass_nxt   = r_pass;
        w_strobe_nxt = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_state_nxt = S_RUN;
                    w_presc_nxt = 16'd0;
                    w_bin_nxt   = 4'd0;
                    w_pass_nxt  = 8'd0;
                end
            end
            S_RUN: begin
                // stop outranks any step or pass completion on the same edge
                if (stop) begin
                    w_state_nxt = S_IDLE;
                    w_presc_nxt = 16'd0;
                    w_bin_nxt   = 4'd0;
                    w_pass_nxt  = 8'd0;
                end else if (r_presc == LP_DIV_M1) begin
                    w_presc_nxt = 16'd0;
                    w_bin_nxt   = r_bin + 4'd1;
                    if (r_bin == 4'hF) begin
                        w_pass_nxt = w_pass_inc;
                        if (w_pass_inc == LP_PASSES) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_strobe_nxt = 1'b1;
                        end
                    end else begin
                        w_strobe_nxt = 1'b1;
                    end
                end else begin
                    w_presc_nxt = r_presc + 16'd1;
                end
            end
            S_DONE: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                    w_pass_nxt  = 8'd0;
                end else if (start) begin
                    w_state_nxt = S_RUN;
                    w_presc_nxt = 16'd0;
                    w_bin_nxt   = 4'd0;
                    w_pass_nxt  = 8'd0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_presc_nxt = 16'd0;
                w_bin_nxt   = 4'd0;
                w_pass_nxt  = 8'd0;
            end
        endcase
    end

`ifdef GRAY_SEQ_EN
    assign w_code_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);
`else
    assign w_code_nxt = w_bin_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_presc  <= 16'd0;
            r_bin    <= 4'd0;
            r_pass   <= 8'd0;
            r_code   <= 4'd0;
            r_strobe <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_presc  <= w_presc_nxt;
            r_bin    <= w_bin_nxt;
            r_pass   <= w_pass_nxt;
            r_code   <= w_code_nxt;
            r_strobe <= w_strobe_nxt;
            r_busy   <= (w_state_nxt == S_RUN);
            r_done   <= (w_state_nxt == S_DONE);
        end
    end

    assign {a, b, c, d} = r_code;
    assign step_strobe  = r_strobe;
    assign busy         = r_busy;
    assign done         = r_done;
    assign pass_cnt     = r_pass;

endmodule

// File: tb/tb_aoi_stimulus_sequencer.sv
// Directed bench: DIV=4/NUM_PASSES=2 instance plus a DIV=1/NUM_PASSES=1 one.
// Expected codes come from a hand-written binary or Gray table.
module tb_aoi_stimulus_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       s0, p0, s1, p1;
    logic       a0, b0, c0, d0, st0, bz0, dn0;
    logic       a1, b1, c1, d1, st1, bz1, dn1;
    logic [7:0] pc0, pc1;
    logic [3:0] code0, code1;
    logic [3:0] seq [16];
    logic [3:0] prev;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         nstr;

    assign code0 = {a0, b0, c0, d0};
    assign code1 = {a1, b1, c1, d1};

    aoi_stimulus_sequencer #(.DIV(4), .NUM_PASSES(2)) u0 (
        .clk(clk), .rst(rst), .start(s0), .stop(p0),
        .a(a0), .b(b0), .c(c0), .d(d0),
        .step_strobe(st0), .busy(bz0), .done(dn0), .pass_cnt(pc0)
    );

    aoi_stimulus_sequencer #(.DIV(1), .NUM_PASSES(1)) u1 (
        .clk(clk), .rst(rst), .start(s1), .stop(p1),
        .a(a1), .b(b1), .c(c1), .d(d1),
        .step_strobe(st1), .busy(bz1), .done(dn1), .pass_cnt(pc1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
`ifdef GRAY_SEQ_EN
        seq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
`else
        seq = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
`endif
        // reset held with start asserted
        rst = 1'b1; s0 = 1'b1; s1 = 1'b1; p0 = 1'b0; p1 = 1'b0;
        tick(3);
        chk("rst_code", code0, 0);
        chk("rst_strobe", st0, 0);
        chk("rst_busy", bz0, 0);
        chk("rst_done", dn0, 0);
        chk("rst_pass", pc0, 0);
        chk("rst_busy1", bz1, 0);
        s0 = 1'b0; s1 = 1'b0; rst = 1'b0;
        tick(1);
        chk("idle_busy", bz0, 0);

        // full two-pass sweep
        s0 = 1'b1;
        tick(1);
        s0 = 1'b0;
        chk("start_busy", bz0, 1);
        chk("start_code", code0, 0);
        chk("start_pass", pc0, 0);
        nstr = 0;
        prev = code0;
        for (int j = 1; j <= 128; j++) begin
            tick(1);
            if (st0) nstr++;
            if (j < 128) begin
                chk("sweep_code", code0, seq[(j / 4) % 16]);
                chk("sweep_strobe", st0, (j % 4 == 0));
                chk("sweep_pass", pc0, (j >= 64));
                chk("sweep_busy", bz0, 1);
            end
`ifdef GRAY_SEQ_EN
            if (st0) chk("gray_hd", $countones(code0 ^ prev), 1);
`endif
            prev = code0;
        end
        chk("end_done", dn0, 1);
        chk("end_busy", bz0, 0);
        chk("end_code", code0, 0);
        chk("end_strobe", st0, 0);
        chk("end_pass", pc0, 2);
        chk("strobe_total", nstr, 31);
        tick(2);
        chk("done_hold", dn0, 1);

        // restart from DONE
        s0 = 1'b1;
        tick(1);
        s0 = 1'b0;
        chk("rs_done", dn0, 0);
        chk("rs_busy", bz0, 1);
        chk("rs_pass", pc0, 0);
        tick(3);
        chk("rs_code3", code0, 0);
        chk("rs_strobe3", st0, 0);
        tick(1);
        chk("rs_code4", code0, seq[1]);
        chk("rs_strobe4", st0, 1);

        // start during RUN is ignored, then stop at code 5
        s0 = 1'b1;
        tick(8);
        s0 = 1'b0;
        chk("ign_code", code0, seq[3]);
        tick(8);
        chk("pre_stop", code0, seq[5]);
        p0 = 1'b1;
        tick(1);
        p0 = 1'b0;
        chk("stop_busy", bz0, 0);
        chk("stop_code", code0, 0);
        chk("stop_pass", pc0, 0);
        chk("stop_done", dn0, 0);
        chk("stop_strobe", st0, 0);
        tick(2);
        chk("stop_idle", bz0, 0);

        // reset mid-run
        s0 = 1'b1;
        tick(1);
        s0 = 1'b0;
        tick(6);
        chk("mid_code", code0, seq[1]);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mrst_busy", bz0, 0);
        chk("mrst_code", code0, 0);

        // DIV=1, single pass
        s1 = 1'b1;
        tick(1);
        s1 = 1'b0;
        chk("d1_busy", bz1, 1);
        for (int j = 1; j <= 15; j++) begin
            tick(1);
            chk("d1_code", code1, seq[j]);
            chk("d1_strobe", st1, 1);
        end
        tick(1);
        chk("d1_done", dn1, 1);
        chk("d1_code0", code1, 0);
        chk("d1_strobe0", st1, 0);
        chk("d1_pass", pc1, 1);
        chk("d1_busy0", bz1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
